// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg -- shared definitions for the chunked pipelined ALU.
//   alu_mode_e   : operation encodings carried on the 2-bit mode input
//   stage_ctrl_t : control portion of each stage register
//   is_arith     : true for the modes that use the adder carry chain
package pipe_alu_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_mode_e;

  // Control fields travelling with a beat. The data fields (partial result,
  // unresolved operand chunks) are sized per stage in the top module because
  // their widths shrink/grow along the pipe.
  typedef struct packed {
    logic              valid;
    logic [MODE_W-1:0] mode;
    logic              carry;  // carry out of the most recently resolved chunk
    logic              zero;   // all chunks resolved so far are zero
  } stage_ctrl_t;

  function automatic logic is_arith(input logic [MODE_W-1:0] m);
    return (m == ALU_ADD) || (m == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_chunk_stage.sv
// alu_chunk_stage -- combinational CHUNK-wide ALU slice.
//   mode  : operation (pipe_alu_pkg encodings)
//   a, b  : operand chunks
//   cin   : carry into this chunk (ADD/SUB only)
//   res   : chunk result
//   cout  : carry out of this chunk (0 for AND/XOR)
//   zero  : res == 0
module alu_chunk_stage
  import pipe_alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [CHUNK-1:0]  a,
  input  logic [CHUNK-1:0]  b,
  input  logic              cin,
  output logic [CHUNK-1:0]  res,
  output logic              cout,
  output logic              zero
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  // Subtraction is a + ~b + 1; the +1 arrives as the carry into chunk 0.
  assign b_eff = (mode == ALU_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};

  always_comb begin
    res  = sum[CHUNK-1:0];
    cout = sum[CHUNK];
    case (mode)
      ALU_AND: begin
        res  = a & b;
        cout = 1'b0;
      end
      ALU_XOR: begin
        res  = a ^ b;
        cout = 1'b0;
      end
      default: ;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu -- WIDTH-bit ALU (ADD/SUB/AND/XOR) resolved CHUNK bits per stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake (in1, in2, mode)
//   out_valid / out_ready: result beat handshake
//   result               : operation result modulo 2^WIDTH
//   overflow, carry      : signed overflow / raw MSB carry (ADD/SUB only)
//   zero, sign           : result == 0, result MSB
// Stage k resolves chunk k. A stage register keeps the result bits resolved
// so far plus only the operand chunks not yet consumed, so storage moves
// from the operand side to the result side along the pipe. The whole pipe
// advances in lockstep whenever the output slot is empty or being taken.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              overflow,
  output logic              carry,
  output logic              zero,
  output logic              sign
);

  localparam int NSTG = WIDTH / CHUNK;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipe_alu: WIDTH must be a positive integer multiple of CHUNK");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  for (gi = 0; gi < NSTG; gi++) begin : g_stage
    localparam int SW = WIDTH - gi * CHUNK;  // unresolved operand bits entering
    localparam int RW = (gi + 1) * CHUNK;    // resolved result bits leaving

    logic              src_valid;
    logic [MODE_W-1:0] src_mode;
    logic [SW-1:0]     src_a;
    logic [SW-1:0]     src_b;
    logic              src_cin;
    logic              src_zero;
    logic [CHUNK-1:0]  chunk_res;
    logic              chunk_cout;
    logic              chunk_zero;
    logic [RW-1:0]     res_next;
    logic [RW-1:0]     res_reg;
    stage_ctrl_t       ctrl_next;
    stage_ctrl_t       ctrl_reg;

    if (gi == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_mode  = mode;
      assign src_a     = in1;
      assign src_b     = in2;
      assign src_cin   = (mode == ALU_SUB);
      assign src_zero  = 1'b1;
      assign res_next  = chunk_res;
    end else begin : g_body
      assign src_valid = g_stage[gi-1].ctrl_reg.valid;
      assign src_mode  = g_stage[gi-1].ctrl_reg.mode;
      assign src_a     = g_stage[gi-1].g_ops.opa_reg;
      assign src_b     = g_stage[gi-1].g_ops.opb_reg;
      assign src_cin   = g_stage[gi-1].ctrl_reg.carry;
      assign src_zero  = g_stage[gi-1].ctrl_reg.zero;
      assign res_next  = {chunk_res, g_stage[gi-1].res_reg};
    end

    alu_chunk_stage #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .mode(src_mode),
      .a   (src_a[CHUNK-1:0]),
      .b   (src_b[CHUNK-1:0]),
      .cin (src_cin),
      .res (chunk_res),
      .cout(chunk_cout),
      .zero(chunk_zero)
    );

    assign ctrl_next = '{
      valid: src_valid,
      mode:  src_mode,
      carry: chunk_cout,
      zero:  src_zero & chunk_zero
    };

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_reg <= '0;
        res_reg  <= '0;
      end else if (adv) begin
        ctrl_reg <= ctrl_next;
        res_reg  <= res_next;
      end
    end

    // Operand chunks still to be resolved by later stages.
    if (SW > CHUNK) begin : g_ops
      logic [SW-CHUNK-1:0] opa_reg;
      logic [SW-CHUNK-1:0] opb_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_reg <= '0;
          opb_reg <= '0;
        end else if (adv) begin
          opa_reg <= src_a[SW-1:CHUNK];
          opb_reg <= src_b[SW-1:CHUNK];
        end
      end
    end

    // The last chunk holds both operand MSBs, so overflow is formed here.
    if (gi == NSTG - 1) begin : g_tail
      logic ovf_next;
      logic ovf_reg;
      logic b_eff_msb;

      assign b_eff_msb = src_b[CHUNK-1] ^ (src_mode == ALU_SUB);
      assign ovf_next  = is_arith(src_mode)
                       && (src_a[CHUNK-1] == b_eff_msb)
                       && (chunk_res[CHUNK-1] != src_a[CHUNK-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= ovf_next;
        end
      end

      assign out_valid = ctrl_reg.valid;
      assign result    = res_reg;
      assign overflow  = ovf_reg;
      assign carry     = ctrl_reg.carry & is_arith(ctrl_reg.mode);
      assign zero      = ctrl_reg.zero;
      assign sign      = res_reg[RW-1];
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu -- self-checking bench for pipe_alu (64/16 and 32/8 instances).
// Expected results come from a plain-arithmetic reference function and a
// FIFO of accepted beats; one line is printed per completed transaction.
module tb_pipe_alu;
  import pipe_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in1, in2, result;
  logic [1:0]  mode;
  logic        overflow, carry, zero, sign;

  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic [31:0] in1_s, in2_s, result_s;
  logic [1:0]  mode_s;
  logic        overflow_s, carry_s, zero_s, sign_s;

  pipe_alu #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .carry(carry),
    .zero(zero), .sign(sign)
  );

  pipe_alu #(.WIDTH(32), .CHUNK(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in1(in1_s), .in2(in2_s), .mode(mode_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .result(result_s), .overflow(overflow_s), .carry(carry_s),
    .zero(zero_s), .sign(sign_s)
  );

  int total = 0;
  int bad   = 0;
  int out_cnt, in_cnt, step_idx, first_out, last_out, stray;
  logic        held_vld;
  logic [63:0] held_res;
  logic [67:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry, zero, sign, result} from the arithmetic
  // definition of each operation (true signed value vs wrapped value).
  function automatic logic [67:0] ref_alu(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        r;
    logic               c, v;
    logic signed [65:0] sa, sb, s;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    s  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (m)
      2'b00: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        s = sa + sb;
        v = (s != $signed({{2{r[63]}}, r}));
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s != $signed({{2{r[63]}}, r}));
      end
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    return {v, c, (r == 64'd0), r[63], r};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // One clock of the streaming handshake; transfers are evaluated just
  // before the edge that performs them.
  task automatic step(input logic v, input logic [1:0] m, input logic [63:0] a,
                      input logic [63:0] b, input logic ordy);
    logic [67:0] e;
    @(posedge clk);
    #1;
    in_valid  = v;
    mode      = m;
    in1       = a;
    in2       = b;
    out_ready = ordy;
    #1;
    step_idx++;
    if (out_valid && !out_ready) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (held_vld) chk("stall_hold", result, held_res);
      else begin
        held_vld = 1'b1;
        held_res = result;
      end
    end else begin
      held_vld = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        stray++;
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e[63:0]);
        chk("flags", {60'd0, overflow, carry, zero, sign}, {60'd0, e[67:64]});
        out_cnt++;
        if (first_out < 0) first_out = step_idx;
        last_out = step_idx;
        $display("out %0d: res=%h ovf=%b c=%b z=%b s=%b", out_cnt, result, overflow, carry, zero, sign);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_alu(mode, in1, in2));
      in_cnt++;
    end
  endtask

  // Single isolated beat on the 64-bit instance; checks latency and outputs.
  task automatic directed(input string tag, input logic [1:0] m, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    mode      = m;
    in1       = a;
    in2       = b;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flags"}, {60'd0, overflow, carry, zero, sign}, {60'd0, exp_flags});
    $display("%s: res=%h ovf=%b c=%b z=%b s=%b lat=%0d", tag, result, overflow, carry, zero, sign, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [67:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in2 = '0; mode = 2'b00; out_ready = 1'b1;
    in_valid_s = 1'b0; in1_s = '0; in2_s = '0; mode_s = 2'b00; out_ready_s = 1'b1;
    out_cnt = 0; in_cnt = 0; step_idx = 0; first_out = -1; last_out = -1; stray = 0;
    held_vld = 1'b0; held_res = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {60'd0, overflow, carry, zero, sign}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid_s", 64'(out_valid_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases; flags are {ovf, carry, zero, sign}
    directed("add_ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1001);
    directed("sub_eq", ALU_SUB, 64'h5, 64'h5, 64'h0, 4'b0110);
    directed("sub_borrow", ALU_SUB, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
    directed("add_chain", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0110);
    directed("and_msb", ALU_AND, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b0001);
    directed("xor_self", ALU_XOR, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'h0, 4'b0010);

    // 32-bit / 8-bit-chunk instance
    @(posedge clk);
    #1;
    in_valid_s = 1'b1; in1_s = 32'h7FFF_FFFF; in2_s = 32'h1; mode_s = ALU_ADD;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid_s = 1'b0;
      lat++;
    end while (!out_valid_s && lat < 20);
    chk("w32_lat", 64'(lat), 64'd4);
    chk("w32_res", {32'd0, result_s}, 64'h8000_0000);
    chk("w32_flags", {60'd0, overflow_s, carry_s, zero_s, sign_s}, 64'b1001);
    $display("w32 add_ovf: res=%h ovf=%b c=%b z=%b s=%b lat=%0d", result_s, overflow_s, carry_s, zero_s, sign_s, lat);

    // 20 back-to-back random beats, then drain
    out_cnt = 0; in_cnt = 0; step_idx = 0; first_out = -1; stray = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 2'($urandom_range(0, 3)), rnd64(), rnd64(), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
    chk("b2b_count", 64'(out_cnt), 64'd20);
    chk("b2b_span", 64'(last_out - first_out), 64'd19);
    chk("b2b_empty", 64'(exp_q.size()), 64'd0);
    chk("b2b_stray", 64'(stray), 64'd0);

    // Stream with a 5-cycle output stall and random bubbles
    out_cnt = 0; in_cnt = 0; stray = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 2'($urandom_range(0, 3)), rnd64(), rnd64(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), rnd64(), rnd64(), 1'b0);
    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd64(), rnd64(), 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
    chk("stall_count", 64'(out_cnt), 64'(in_cnt));
    chk("stall_empty", 64'(exp_q.size()), 64'd0);
    chk("stall_stray", 64'(stray), 64'd0);

    // Reset with three beats in flight
    out_cnt = 0; stray = 0;
    for (int i = 0; i < 3; i++) step(1'b1, ALU_ADD, rnd64(), rnd64(), 1'b1);
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    chk("inflight_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_flags", {60'd0, overflow, carry, zero, sign}, 64'd0);
    exp_q.delete();
    held_vld = 1'b0;

    // Release and offer a beat for the very first edge afterwards
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; mode = ALU_SUB; in1 = 64'h10; in2 = 64'h3; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    if (in_valid && in_ready) exp_q.push_back(ref_alu(mode, in1, in2));
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 64'd0, 64'd0, 1'b1);
    chk("post_rst_count", 64'(out_cnt), 64'd1);
    chk("post_rst_empty", 64'(exp_q.size()), 64'd0);
    chk("post_rst_stray", 64'(stray), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
